// File: rtl/dcache_pkg.sv
// Shared types and address-layout constants for the direct-mapped,
// write-through, no-write-allocate data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_e;

    localparam int DCACHE_DW  = 32;
    localparam int DCACHE_AW  = 32;
    localparam int DCACHE_SETS = 16;
    localparam int DCACHE_WPL = 4;

    localparam int OFF_W     = 2;
    localparam int WORD_W    = $clog2(DCACHE_WPL);
    localparam int INDEX_W   = $clog2(DCACHE_SETS);
    localparam int TAG_W     = DCACHE_AW - OFF_W - WORD_W - INDEX_W;
    localparam int WORD_LSB  = OFF_W;
    localparam int INDEX_LSB = WORD_LSB + WORD_W;
    localparam int TAG_LSB   = INDEX_LSB + INDEX_W;

endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data arrays: one combinational read port and one
// synchronous write port (word write, optional tag/valid update).
module dcache_store #(
    parameter int DW = 32,
    parameter int TB = 24,
    parameter int IB = 4,
    parameter int WB = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [IB-1:0] rd_idx_i,
    input  logic [WB-1:0] rd_word_i,
    output logic          rd_valid_o,
    output logic [TB-1:0] rd_tag_o,
    output logic [DW-1:0] rd_data_o,
    input  logic          wr_en_i,
    input  logic          wr_line_i,
    input  logic [IB-1:0] wr_idx_i,
    input  logic [WB-1:0] wr_word_i,
    input  logic [TB-1:0] wr_tag_i,
    input  logic [DW-1:0] wr_data_i
);

    localparam int SETS  = 2 ** IB;
    localparam int DEPTH = 2 ** (IB + WB);

    logic [SETS-1:0] valid_q, valid_d;
    logic [TB-1:0]   tag_q  [SETS];
    logic [TB-1:0]   tag_d  [SETS];
    logic [DW-1:0]   data_q [DEPTH];
    logic [DW-1:0]   data_d [DEPTH];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[{rd_idx_i, rd_word_i}];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en_i) begin
            data_d[{wr_idx_i, wr_word_i}] = wr_data_i;
            if (wr_line_i) begin
                tag_d[wr_idx_i]   = wr_tag_i;
                valid_d[wr_idx_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache.sv
// Memory-stage data cache: load hits in zero cycles, misses refill a
// whole line; stores always write through to memory.
module dcache
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH     = DCACHE_DW,
    parameter int ADDRESS_WIDTH  = DCACHE_AW,
    parameter int SETS           = DCACHE_SETS,
    parameter int WORDS_PER_LINE = DCACHE_WPL
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     RdEn_i,
    input  logic                     WrEn_i,
    input  logic [ADDRESS_WIDTH-1:0] Addr_i,
    input  logic [DATA_WIDTH-1:0]    WD_i,
    output logic [DATA_WIDTH-1:0]    RD_o,
    output logic                     Stall_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    input  logic                     mem_ack_i,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);

    localparam int AW      = ADDRESS_WIDTH;
    localparam int DW      = DATA_WIDTH;
    localparam int WB      = $clog2(WORDS_PER_LINE);
    localparam int IB      = $clog2(SETS);
    localparam int TB      = AW - OFF_W - WB - IB;
    localparam int IDX_LSB = OFF_W + WB;
    localparam int TAG_LSB = IDX_LSB + IB;

    localparam logic [AW-1:0] WORD_MASK =
        {{(AW - OFF_W){1'b1}}, {OFF_W{1'b0}}};
    localparam logic [AW-1:0] LINE_MASK =
        {{(AW - IDX_LSB){1'b1}}, {IDX_LSB{1'b0}}};
    localparam logic [WB-1:0] LAST_WORD = WB'(WORDS_PER_LINE - 1);

    state_e        state_q, state_d;
    logic [WB-1:0] cnt_q, cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic [AW-1:0] lk_addr;
    logic [IB-1:0] lk_idx;
    logic [WB-1:0] lk_word;
    logic [TB-1:0] lk_tag;
    logic          rd_valid;
    logic [TB-1:0] rd_tag;
    logic          hit;

    logic          st_we;
    logic          st_line;
    logic [WB-1:0] st_word;
    logic [DW-1:0] st_wdata;

    // Outside IDLE the lookup follows the registered line/store address.
    always_comb begin
        lk_addr = (state_q == IDLE) ? Addr_i : base_q;
        lk_word = WB'(lk_addr >> OFF_W);
        lk_idx  = IB'(lk_addr >> IDX_LSB);
        lk_tag  = TB'(lk_addr >> TAG_LSB);
        hit     = rd_valid && (rd_tag == lk_tag);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        Stall_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        st_we       = 1'b0;
        st_line     = 1'b0;
        st_word     = lk_word;
        st_wdata    = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (WrEn_i) begin
                    Stall_o = 1'b1;
                    state_d = WRITE;
                    base_d  = Addr_i & WORD_MASK;
                    wdata_d = WD_i;
                end else if (RdEn_i && !hit) begin
                    Stall_o = 1'b1;
                    state_d = FILL;
                    cnt_d   = '0;
                    base_d  = Addr_i & LINE_MASK;
                end
            end
            FILL: begin
                Stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = base_q | (AW'(cnt_q) << OFF_W);
                st_word    = cnt_q;
                st_wdata   = mem_rdata_i;
                if (mem_ack_i) begin
                    st_we = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        st_line = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                Stall_o     = !mem_ack_i;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = base_q;
                mem_wdata_o = wdata_q;
                if (mem_ack_i) begin
                    st_we   = hit;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
        end
    end

    dcache_store #(
        .DW(DW),
        .TB(TB),
        .IB(IB),
        .WB(WB)
    ) u_store (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_idx_i  (lk_idx),
        .rd_word_i (lk_word),
        .rd_valid_o(rd_valid),
        .rd_tag_o  (rd_tag),
        .rd_data_o (RD_o),
        .wr_en_i   (st_we && !rst_i),
        .wr_line_i (st_line),
        .wr_idx_i  (lk_idx),
        .wr_word_i (st_word),
        .wr_tag_i  (lk_tag),
        .wr_data_i (st_wdata)
    );

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: transaction table plus hand-written
// sequences for cold fill, pipelined address order and reset mid-fill.
module tb_dcache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dcache dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .RdEn_i     (rd_en),
        .WrEn_i     (wr_en),
        .Addr_i     (addr),
        .WD_i       (wd),
        .RD_o       (rd),
        .Stall_o    (stall),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_ack_i  (mem_ack),
        .mem_rdata_i(mem_rdata)
    );

    // Memory model: unwritten word i reads as i + 0x60, so 0x100 -> 0xA0.
    logic [1023:0] wr_valid = '0;
    logic [31:0]   wr_mem [1024];
    int            lat = 0;
    int            wcnt = 0;
    logic [9:0]    midx;

    assign midx      = mem_addr[11:2];
    assign mem_ack   = mem_req && (wcnt == lat);
    assign mem_rdata = wr_valid[midx] ? wr_mem[midx]
                                      : 32'(midx) + 32'h60;

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
        if (mem_req && mem_ack && mem_we) begin
            wr_mem[midx]   <= mem_wdata;
            wr_valid[midx] <= 1'b1;
        end
    end

    logic [31:0] addrs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic access(input logic w, input logic r,
                          input logic [31:0] a, input logic [31:0] d,
                          input int l, output int st, output int rq,
                          output logic [31:0] rdv);
        bit done = 0;
        @(posedge clk) #1;
        lat = l;
        wr_en = w;
        rd_en = r;
        addr = a;
        wd = d;
        st = 0;
        rq = 0;
        rdv = 'x;
        addrs.delete();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (addr !== a || wr_en !== w || rd_en !== r) begin
                n_err++;
                $display("FAIL input_stable at %h", a);
            end
            if (mem_req) begin
                rq++;
                addrs.push_back(mem_addr);
            end
            if (!stall) begin
                rdv = rd;
                done = 1;
                break;
            end
            st++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: addr %h stall stuck", a);
        end
        @(posedge clk) #1;
        wr_en = 0;
        rd_en = 0;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        logic [31:0] exp_rd;
        int          exp_stall;
        int          exp_req;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int          st;
        int          rq;
        logic [31:0] rdv;

        rst = 1;
        rd_en = 0;
        wr_en = 0;
        addr = 0;
        wd = 0;

        vecs[0]  = '{0, 1, 32'h104, 0, 0, 32'hA1, 0, 0};
        vecs[1]  = '{1, 0, 32'h108, 32'h12345678, 3, 0, 4, 4};
        vecs[2]  = '{0, 1, 32'h108, 0, 0, 32'h12345678, 0, 0};
        vecs[3]  = '{0, 1, 32'h200, 0, 1, 32'hE0, 9, 8};
        vecs[4]  = '{0, 1, 32'h100, 0, 0, 32'hA0, 5, 4};
        vecs[5]  = '{0, 1, 32'h10C, 0, 0, 32'hA3, 0, 0};
        vecs[6]  = '{0, 1, 32'h108, 0, 0, 32'h12345678, 0, 0};
        vecs[7]  = '{1, 0, 32'h300, 32'hDEADBEEF, 2, 0, 3, 3};
        vecs[8]  = '{0, 1, 32'h300, 0, 0, 32'hDEADBEEF, 5, 4};
        vecs[9]  = '{0, 1, 32'h100, 0, 0, 32'hA0, 5, 4};
        vecs[10] = '{1, 1, 32'h104, 32'h55, 0, 0, 1, 1};
        vecs[11] = '{0, 1, 32'h104, 0, 0, 32'h55, 0, 0};

        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);

        access(0, 1, 32'h100, 0, 0, st, rq, rdv);
        chk("cold_stall", 32'(st), 5);
        chk("cold_req", 32'(rq), 4);
        chk("cold_rd", rdv, 32'hA0);
        chk("cold_naddr", 32'(addrs.size()), 4);
        for (int i = 0; i < addrs.size() && i < 4; i++)
            chk($sformatf("cold_addr%0d", i), addrs[i], 32'h100 + 32'(4 * i));

        foreach (vecs[i]) begin
            access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd,
                   vecs[i].lat, st, rq, rdv);
            chk($sformatf("v%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
            chk($sformatf("v%0d_req", i), 32'(rq), 32'(vecs[i].exp_req));
            if (!vecs[i].wr)
                chk($sformatf("v%0d_rd", i), rdv, vecs[i].exp_rd);
        end

        // Reset after two acks of a zero-wait fill of 0x140.
        @(posedge clk) #1;
        lat = 0;
        rd_en = 1;
        addr = 32'h140;
        @(negedge clk);
        chk("mf_stall0", 32'(stall), 1);
        chk("mf_req0", 32'(mem_req), 0);
        @(posedge clk) #1;
        @(negedge clk);
        chk("mf_addr0", mem_addr, 32'h140);
        @(posedge clk) #1;
        @(negedge clk);
        chk("mf_addr1", mem_addr, 32'h144);
        @(posedge clk) #1;
        rst = 1;
        rd_en = 0;
        @(posedge clk) #1;
        rst = 0;
        @(negedge clk);
        chk("mf_req_after", 32'(mem_req), 0);
        chk("mf_stall_after", 32'(stall), 0);
        chk("mf_addr_after", mem_addr, 0);

        access(0, 1, 32'h140, 0, 0, st, rq, rdv);
        chk("mf_reload_stall", 32'(st), 5);
        chk("mf_reload_req", 32'(rq), 4);
        chk("mf_reload_rd", rdv, 32'hB0);
        access(0, 1, 32'h100, 0, 0, st, rq, rdv);
        chk("post_rst_stall", 32'(st), 5);
        chk("post_rst_rd", rdv, 32'hA0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
